// File: rtl/control_unit_pkg.sv
// cpu_defs: constants shared by the sequencer and the datapath.
//   ALU_*   ALU operation codes (alu_operation encoding)
//   OP_*    instruction opcodes found in IR[15:12]
//   *_MSB   bit positions of the instruction fields
//   FLAG_*  bit indices into the datapath flags vector
//   state_t sequencer state encoding (also exported on state_dbg)
package cpu_defs;

    localparam logic [3:0] ALU_PASS = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_AND  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_NOT  = 4'h6;
    localparam logic [3:0] ALU_SHL  = 4'h7;
    localparam logic [3:0] ALU_SHR  = 4'h8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_ALU  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_LMAR = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_MSB    = 15;
    localparam int RD_MSB    = 11;
    localparam int RS_MSB    = 8;
    localparam int ALUOP_MSB = 3;
    localparam int IMM_MSB   = 7;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;

    typedef enum logic [3:0] {
        S_FETCH_H  = 4'd0,
        S_FETCH_L  = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_MOV = 4'd3,
        S_EXEC_IMM = 4'd4,
        S_EXEC_A   = 4'd5,
        S_EXEC_WB  = 4'd6,
        S_EXEC_LD  = 4'd7,
        S_EXEC_ST  = 4'd8,
        S_LMAR_H   = 4'd9,
        S_LMAR_L   = 4'd10,
        S_JR_H     = 4'd11,
        S_JR_L     = 4'd12,
        S_PCSET    = 4'd13,
        S_HALT     = 4'd14
    } state_t;

endpackage

// File: rtl/control_unit_mem_handshake.sv
// mem_handshake: single-byte memory request generator.
//   active  in   current state wants a byte transfer
//   write   in   transfer direction (1 = write)
//   mem_ack in   memory completes the byte this cycle
//   mem_req out  request to memory
//   mem_we  out  write qualifier, only meaningful with mem_req
//   done    out  transfer completes this cycle
// Purely combinational: the requesting state simply waits for done, so a
// missing ack holds the request (and everything else) stable forever.
module mem_handshake (
    input  logic active,
    input  logic write,
    input  logic mem_ack,
    output logic mem_req,
    output logic mem_we,
    output logic done
);
    assign mem_req = active;
    assign mem_we  = active & write;
    assign done    = active & mem_ack;
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for data_path.
//   clock, reset(async, active-low), run       control
//   ir_value, flags, mem_ack                   status inputs
//   mem_req, mem_we, addr_sel                  memory interface
//   gp_*, alu_*, latch_alu, mar_*, ir_*, jr_*, pc_*   data_path strobes/selects
//   halted, state_dbg                          status outputs
//
// state      | meaning
// FETCH_H    | fetch instruction high byte into IR (only while run)
// FETCH_L    | fetch instruction low byte into IR
// DECODE     | idle cycle, dispatch on opcode
// EXEC_MOV   | rd <= rs over the bus
// EXEC_IMM   | ALU latches imm8 (passthrough) for LDI
// EXEC_A     | ALU latches rd op rs
// EXEC_WB    | ALU result written back to rd
// EXEC_LD    | rd <= mem[MAR]
// EXEC_ST    | mem[MAR] <= rs
// LMAR_H/L   | next two program bytes into MAR
// JR_H/L     | next two program bytes into JR
// PCSET      | PC <= JR (JZ: only when zero flag set)
// HALT       | stopped, only reset exits
module control_unit
    import cpu_defs::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int REG_SEL_W = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic [15:0]          ir_value,
    input  logic [2:0]           flags,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 addr_sel,
    output logic                 gp_write,
    output logic                 gp_read,
    output logic                 latch_alu,
    output logic                 alu_store_high,
    output logic                 alu_store_low,
    output logic                 mar_load_high,
    output logic                 mar_load_low,
    output logic                 ir_load_high,
    output logic                 ir_load_low,
    output logic                 jr_load_high,
    output logic                 jr_load_low,
    output logic                 pc_increment,
    output logic                 pc_set,
    output logic [REG_SEL_W-1:0] gp_input_select,
    output logic [REG_SEL_W-1:0] gp_output_select,
    output logic [REG_SEL_W-1:0] gp_alu_output_select,
    output logic [3:0]           alu_operation,
    output logic                 halted,
    output logic [3:0]           state_dbg
);
    state_t state, state_nxt;

    logic [OPCODE_W-1:0]  op;
    logic [REG_SEL_W-1:0] rd, rs;
    logic [3:0]           aluop;
    logic                 req_active, done;
    logic                 unused_fields;

    assign op    = ir_value[OP_MSB -: OPCODE_W];
    assign rd    = ir_value[RD_MSB -: REG_SEL_W];
    assign rs    = ir_value[RS_MSB -: REG_SEL_W];
    assign aluop = ir_value[ALUOP_MSB -: 4];
    // imm8 reaches the bus through data_path, carry/negative are not used here
    assign unused_fields = ^{flags, ir_value};

    assign state_dbg = state;

    // Gating FETCH_H with reset keeps mem_req low while reset is held,
    // even though the state register already sits in FETCH_H.
    always_comb begin
        req_active = 1'b0;
        case (state)
            S_FETCH_H: req_active = run & reset;
            S_FETCH_L, S_EXEC_LD, S_EXEC_ST,
            S_LMAR_H, S_LMAR_L, S_JR_H, S_JR_L: req_active = 1'b1;
            default: req_active = 1'b0;
        endcase
    end

    mem_handshake u_hs (
        .active  (req_active),
        .write   (state == S_EXEC_ST),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .mem_we  (mem_we),
        .done    (done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_FETCH_H;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH_H:  if (done) state_nxt = S_FETCH_L;
            S_FETCH_L:  if (done) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MOV:          state_nxt = S_EXEC_MOV;
                    OP_LDI:          state_nxt = S_EXEC_IMM;
                    OP_ALU:          state_nxt = S_EXEC_A;
                    OP_LD:           state_nxt = S_EXEC_LD;
                    OP_ST:           state_nxt = S_EXEC_ST;
                    OP_LMAR:         state_nxt = S_LMAR_H;
                    OP_JMP, OP_JZ:   state_nxt = S_JR_H;
                    OP_HALT:         state_nxt = S_HALT;
                    default:         state_nxt = S_FETCH_H;
                endcase
            end
            S_EXEC_MOV: state_nxt = S_FETCH_H;
            S_EXEC_IMM: state_nxt = S_EXEC_WB;
            S_EXEC_A:   state_nxt = S_EXEC_WB;
            S_EXEC_WB:  state_nxt = S_FETCH_H;
            S_EXEC_LD:  if (done) state_nxt = S_FETCH_H;
            S_EXEC_ST:  if (done) state_nxt = S_FETCH_H;
            S_LMAR_H:   if (done) state_nxt = S_LMAR_L;
            S_LMAR_L:   if (done) state_nxt = S_FETCH_H;
            S_JR_H:     if (done) state_nxt = S_JR_L;
            S_JR_L:     if (done) state_nxt = S_PCSET;
            S_PCSET:    state_nxt = S_FETCH_H;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_FETCH_H;
        endcase
    end

    always_comb begin
        addr_sel             = 1'b0;
        gp_write             = 1'b0;
        gp_read              = 1'b0;
        latch_alu            = 1'b0;
        alu_store_high       = 1'b0;
        alu_store_low        = 1'b0;
        mar_load_high        = 1'b0;
        mar_load_low         = 1'b0;
        ir_load_high         = 1'b0;
        ir_load_low          = 1'b0;
        jr_load_high         = 1'b0;
        jr_load_low          = 1'b0;
        pc_increment         = 1'b0;
        pc_set               = 1'b0;
        gp_input_select      = '0;
        gp_output_select     = '0;
        gp_alu_output_select = '0;
        alu_operation        = ALU_PASS;
        halted               = 1'b0;
        case (state)
            S_FETCH_H: begin
                ir_load_high = done;
                pc_increment = done;
            end
            S_FETCH_L: begin
                ir_load_low  = done;
                pc_increment = done;
            end
            S_EXEC_MOV: begin
                gp_output_select = rs;
                gp_write         = 1'b1;
                gp_input_select  = rd;
                gp_read          = 1'b1;
            end
            S_EXEC_IMM: begin
                alu_operation = ALU_PASS;
                latch_alu     = 1'b1;
            end
            S_EXEC_A: begin
                gp_alu_output_select = rd;
                gp_output_select     = rs;
                gp_write             = 1'b1;
                alu_operation        = aluop;
                latch_alu            = 1'b1;
            end
            S_EXEC_WB: begin
                alu_store_low   = 1'b1;
                gp_read         = 1'b1;
                gp_input_select = rd;
            end
            S_EXEC_LD: begin
                addr_sel        = 1'b1;
                gp_input_select = rd;
                gp_read         = done;
            end
            S_EXEC_ST: begin
                addr_sel         = 1'b1;
                gp_output_select = rs;
                gp_write         = 1'b1;
            end
            S_LMAR_H: begin
                mar_load_high = done;
                pc_increment  = done;
            end
            S_LMAR_L: begin
                mar_load_low = done;
                pc_increment = done;
            end
            S_JR_H: begin
                jr_load_high = done;
                pc_increment = done;
            end
            S_JR_L: begin
                jr_load_low  = done;
                pc_increment = done;
            end
            S_PCSET:  pc_set = (op == OP_JZ) ? flags[FLAG_ZERO] : 1'b1;
            S_HALT:   halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
    import cpu_defs::*;

    logic        clock = 1'b0;
    logic        reset, run, mem_ack;
    logic [15:0] ir_value;
    logic [2:0]  flags;
    logic mem_req, mem_we, addr_sel, gp_write, gp_read, latch_alu;
    logic alu_store_high, alu_store_low, mar_load_high, mar_load_low;
    logic ir_load_high, ir_load_low, jr_load_high, jr_load_low;
    logic pc_increment, pc_set, halted;
    logic [2:0] gp_input_select, gp_output_select, gp_alu_output_select;
    logic [3:0] alu_operation, state_dbg;

    always #5 clock = ~clock;

    control_unit dut (
        .clock(clock), .reset(reset), .run(run), .ir_value(ir_value),
        .flags(flags), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .gp_write(gp_write), .gp_read(gp_read),
        .latch_alu(latch_alu), .alu_store_high(alu_store_high),
        .alu_store_low(alu_store_low), .mar_load_high(mar_load_high),
        .mar_load_low(mar_load_low), .ir_load_high(ir_load_high),
        .ir_load_low(ir_load_low), .jr_load_high(jr_load_high),
        .jr_load_low(jr_load_low), .pc_increment(pc_increment), .pc_set(pc_set),
        .gp_input_select(gp_input_select), .gp_output_select(gp_output_select),
        .gp_alu_output_select(gp_alu_output_select), .alu_operation(alu_operation),
        .halted(halted), .state_dbg(state_dbg)
    );

    // ---------------- datapath + memory model ----------------
    logic [7:0]  rom [0:255];
    logic [7:0]  ram [0:65535];
    logic [7:0]  regs [0:7];
    logic [15:0] pc, mar, jr, ir, addr;
    logic [7:0]  alu_res, bus, alu_a;
    logic [8:0]  alu_calc;
    logic        z_flag, c_flag, n_flag;
    int          ack_delay = 0;
    int          wait_cnt;

    assign ir_value = ir;
    assign flags    = {n_flag, c_flag, z_flag};
    assign addr     = addr_sel ? mar : pc;
    assign mem_ack  = mem_req && (wait_cnt == ack_delay);

    always_comb begin
        bus = 8'h00;
        if (mem_req && !mem_we) bus = addr_sel ? ram[addr] : rom[addr[7:0]];
        else if (gp_write)      bus = regs[gp_output_select];
        else if (alu_store_low) bus = alu_res;
        else if (latch_alu)     bus = ir[7:0];
    end

    always_comb begin
        alu_a = regs[gp_alu_output_select];
        case (alu_operation)
            ALU_ADD: alu_calc = {1'b0, alu_a} + {1'b0, bus};
            ALU_SUB: alu_calc = {1'b0, alu_a} - {1'b0, bus};
            ALU_AND: alu_calc = {1'b0, alu_a & bus};
            ALU_OR:  alu_calc = {1'b0, alu_a | bus};
            ALU_XOR: alu_calc = {1'b0, alu_a ^ bus};
            default: alu_calc = {1'b0, bus};
        endcase
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc <= '0; ir <= '0; mar <= '0; jr <= '0; alu_res <= '0;
            z_flag <= 1'b0; c_flag <= 1'b0; n_flag <= 1'b0; wait_cnt <= 0;
        end else begin
            if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
            else                     wait_cnt <= 0;
            if (ir_load_high)  ir[15:8]  <= bus;
            if (ir_load_low)   ir[7:0]   <= bus;
            if (mar_load_high) mar[15:8] <= bus;
            if (mar_load_low)  mar[7:0]  <= bus;
            if (jr_load_high)  jr[15:8]  <= bus;
            if (jr_load_low)   jr[7:0]   <= bus;
            if (pc_set)            pc <= jr;
            else if (pc_increment) pc <= pc + 16'd1;
            if (gp_read) regs[gp_input_select] <= bus;
            if (latch_alu) begin
                alu_res <= alu_calc[7:0];
                c_flag  <= alu_calc[8];
                z_flag  <= (alu_calc[7:0] == 8'h00);
                n_flag  <= alu_calc[7];
            end
            if (mem_req && mem_we && mem_ack) ram[addr] <= bus;
        end
    end

    // ---------------- checking helpers ----------------
    localparam logic [16:0] M_REQ = 17'h10000, M_WE   = 17'h08000, M_ASEL = 17'h04000;
    localparam logic [16:0] M_HLT = 17'h02000, M_GPW  = 17'h01000, M_GPR  = 17'h00800;
    localparam logic [16:0] M_LAT = 17'h00400, M_STL  = 17'h00100;
    localparam logic [16:0] M_MRH = 17'h00080, M_IRH  = 17'h00020;
    localparam logic [16:0] M_JRH = 17'h00008, M_PCI  = 17'h00002, M_PCS = 17'h00001;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [33:0] outs();
        return {state_dbg, mem_req, mem_we, addr_sel, halted, gp_write, gp_read,
                latch_alu, alu_store_high, alu_store_low, mar_load_high, mar_load_low,
                ir_load_high, ir_load_low, jr_load_high, jr_load_low, pc_increment,
                pc_set, gp_input_select, gp_output_select, gp_alu_output_select,
                alu_operation};
    endfunction

    function automatic logic [33:0] ev(input logic [3:0] st, input logic [16:0] s,
                                       input logic [2:0] isel, input logic [2:0] osel,
                                       input logic [2:0] asel, input logic [3:0] aop);
        return {st, s, isel, osel, asel, aop};
    endfunction

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        step();
        step();
    endtask

    task automatic start(input int dly);
        ack_delay = dly;
        reset     = 1'b1;
        run       = 1'b1;
    endtask

    task automatic put16(input int a, input logic [15:0] w);
        rom[a]     = w[15:8];
        rom[a + 1] = w[7:0];
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int n;
        n = 0;
        #1;
        while (state_dbg !== s && n < budget) begin
            step();
            n++;
        end
        if (state_dbg !== s) check(nm, 64'(state_dbg), 64'(s));
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  st;
        logic [16:0] strb;
        logic [2:0]  isel, osel, asel;
        logic [3:0]  aop;
    } vec_t;

    vec_t vecs [12];
    int   bad, cnt, ih, il;

    initial begin
        reset = 1'b0;
        run   = 1'b0;

        // state and outputs one cycle after DECODE, ack immediate
        vecs[0]  = '{16'h0000, S_FETCH_H,  M_REQ | M_IRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[1]  = '{16'h1280, S_EXEC_MOV, M_GPW | M_GPR,                 3'd1, 3'd2, 3'd0, ALU_PASS};
        vecs[2]  = '{16'h2A5C, S_EXEC_IMM, M_LAT,                         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[3]  = '{16'h3281, S_EXEC_A,   M_GPW | M_LAT,                 3'd0, 3'd2, 3'd1, ALU_ADD};
        vecs[4]  = '{16'h4600, S_EXEC_LD,  M_REQ | M_ASEL | M_GPR,        3'd3, 3'd0, 3'd0, ALU_PASS};
        vecs[5]  = '{16'h5140, S_EXEC_ST,  M_REQ | M_WE | M_ASEL | M_GPW, 3'd0, 3'd5, 3'd0, ALU_PASS};
        vecs[6]  = '{16'h6000, S_LMAR_H,   M_REQ | M_MRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[7]  = '{16'h7000, S_JR_H,     M_REQ | M_JRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[8]  = '{16'h8000, S_JR_H,     M_REQ | M_JRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[9]  = '{16'h9000, S_FETCH_H,  M_REQ | M_IRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[10] = '{16'hF000, S_HALT,     M_HLT,                         3'd0, 3'd0, 3'd0, ALU_PASS};
        vecs[11] = '{16'hE123, S_FETCH_H,  M_REQ | M_IRH | M_PCI,         3'd0, 3'd0, 3'd0, ALU_PASS};

        for (int i = 0; i < 12; i++) begin
            do_reset();
            put16(0, vecs[i].instr);
            start(0);
            wait_state(S_DECODE, 10, $sformatf("vec%0d_reach_decode", i));
            step();
            check($sformatf("vec%0d_%h", i, vecs[i].instr), 64'(outs()),
                  64'(ev(vecs[i].st, vecs[i].strb, vecs[i].isel, vecs[i].osel,
                         vecs[i].asel, vecs[i].aop)));
        end

        // reset mid FETCH_L, outputs clear asynchronously
        do_reset();
        start(3);
        wait_state(S_FETCH_L, 20, "rst_reach_fetch_l");
        reset = 1'b0;
        #1;
        check("rst_async_outs", 64'(outs()), 64'h0);
        step();
        check("rst_held_outs", 64'(outs()), 64'h0);
        reset = 1'b1;
        #1;
        check("rst_release_fetch", 64'(outs()), 64'(ev(S_FETCH_H, M_REQ, 0, 0, 0, ALU_PASS)));

        // run low: parked in FETCH_H with nothing asserted
        do_reset();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (outs() !== 34'h0) bad++;
            step();
        end
        check("run_low_idle", 64'(bad), 64'd0);

        // fetch AB CD with 2-cycle ack delay
        do_reset();
        rom[0] = 8'hAB;
        rom[1] = 8'hCD;
        start(2);
        #1;
        ih = 0; il = 0; bad = 0; cnt = 0;
        while (state_dbg !== S_DECODE && cnt < 30) begin
            if (ir_load_high) ih++;
            if (ir_load_low) il++;
            if (!mem_req || addr_sel || mem_we) bad++;
            step();
            cnt++;
        end
        check("fetch_reach_decode", 64'(state_dbg), 64'(S_DECODE));
        check("fetch_cycles", 64'(cnt), 64'd6);
        check("fetch_ir_high_pulses", 64'(ih), 64'd1);
        check("fetch_ir_low_pulses", 64'(il), 64'd1);
        check("fetch_pc", 64'(pc), 64'd2);
        check("fetch_ir", 64'(ir), 64'hABCD);
        check("fetch_req_stable", 64'(bad), 64'd0);

        // LDI R1,1 ; LDI R2,2 ; ADD R1,R2 ; HALT
        do_reset();
        put16(0, 16'h2201);
        put16(2, 16'h2402);
        put16(4, 16'h3281);
        put16(6, 16'hF000);
        start(0);
        wait_state(S_EXEC_A, 60, "alu_reach_exec_a");
        check("alu_exec_a", 64'(outs()), 64'(ev(S_EXEC_A, M_GPW | M_LAT, 0, 2, 1, ALU_ADD)));
        step();
        check("alu_exec_wb", 64'(outs()), 64'(ev(S_EXEC_WB, M_STL | M_GPR, 1, 0, 0, ALU_PASS)));
        step();
        check("alu_r1", 64'(regs[1]), 64'd3);
        check("alu_zero_flag", 64'(flags[FLAG_ZERO]), 64'd0);
        check("alu_back_to_fetch", 64'(state_dbg), 64'(S_FETCH_H));

        // JMP 1234
        do_reset();
        put16(0, 16'h7000);
        put16(2, 16'h1234);
        start(1);
        wait_state(S_PCSET, 40, "jmp_reach_pcset");
        check("jmp_pcset_outs", 64'(outs()), 64'(ev(S_PCSET, M_PCS, 0, 0, 0, ALU_PASS)));
        step();
        check("jmp_pc", 64'(pc), 64'h1234);

        // JZ with zero clear: sequential
        do_reset();
        put16(0, 16'h8000);
        put16(2, 16'h1234);
        start(1);
        wait_state(S_PCSET, 40, "jz_nt_reach_pcset");
        check("jz_nt_pcset_outs", 64'(outs()), 64'(ev(S_PCSET, 17'h0, 0, 0, 0, ALU_PASS)));
        step();
        check("jz_nt_pc", 64'(pc), 64'd4);

        // LDI R0,0 sets zero, then JZ is taken
        do_reset();
        put16(0, 16'h2000);
        put16(2, 16'h8000);
        put16(4, 16'h1234);
        start(0);
        wait_state(S_PCSET, 40, "jz_t_reach_pcset");
        check("jz_t_pcset_outs", 64'(outs()), 64'(ev(S_PCSET, M_PCS, 0, 0, 0, ALU_PASS)));
        step();
        check("jz_t_pc", 64'(pc), 64'h1234);

        // LDI R5,77 ; LMAR FEEF ; ST [MAR],R5 with 2-cycle ack
        do_reset();
        put16(0, 16'h2A77);
        put16(2, 16'h6000);
        put16(4, 16'hFEEF);
        put16(6, 16'h5140);
        put16(8, 16'hF000);
        start(2);
        wait_state(S_EXEC_ST, 80, "st_reach_exec_st");
        bad = 0;
        cnt = 0;
        while (state_dbg === S_EXEC_ST && cnt < 10) begin
            if (!(mem_req && mem_we && addr_sel && gp_write) || bus !== 8'h77 ||
                addr !== 16'hFEEF) bad++;
            step();
            cnt++;
        end
        check("st_cycles", 64'(cnt), 64'd3);
        check("st_bus_held", 64'(bad), 64'd0);
        check("st_mar", 64'(mar), 64'hFEEF);
        check("st_mem_written", 64'(ram[16'hFEEF]), 64'h77);

        // HALT: no requests, reset is the only exit
        do_reset();
        put16(0, 16'hF000);
        start(0);
        wait_state(S_HALT, 20, "halt_reach");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (outs() !== ev(S_HALT, M_HLT, 0, 0, 0, ALU_PASS)) bad++;
            step();
        end
        check("halt_quiet", 64'(bad), 64'd0);
        reset = 1'b0;
        #1;
        check("halt_reset_clears", 64'(outs()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
